// File: rtl/regmst_pkg.sv
// Shared types for the register-access initiator: FSM states and the latched command.
package regmst_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    RSP      = 2'd2,
    GAP      = 2'd3
  } regmst_state_e;

  typedef struct packed {
    logic              wr;
    logic              sync_rst;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } regmst_cmd_t;

endpackage

// File: rtl/regmst_initiator_if.sv
// Command, response and regslv-side request/ack signals of the register initiator.
interface regmst_initiator_if
  import regmst_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_W,
  parameter int unsigned DATA_WIDTH = DATA_W
);

  // host command port
  logic                  cmd_vld;
  logic                  cmd_rdy;
  logic                  cmd_wr;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  cmd_sync_rst;

  // host response port
  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  // regslv request/ack
  logic                  req_vld;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  global_sync_reset_out;
  logic                  ack_vld;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    input  cmd_vld, cmd_wr, cmd_addr, cmd_wdata, cmd_sync_rst,
    output cmd_rdy,
    output rsp_vld, rsp_rdata, rsp_err,
    input  rsp_rdy,
    output req_vld, wr_en, rd_en, addr, wr_data, global_sync_reset_out,
    input  ack_vld, rd_data
  );

  modport slave (
    output cmd_vld, cmd_wr, cmd_addr, cmd_wdata, cmd_sync_rst,
    input  cmd_rdy,
    input  rsp_vld, rsp_rdata, rsp_err,
    output rsp_rdy,
    input  req_vld, wr_en, rd_en, addr, wr_data, global_sync_reset_out,
    output ack_vld, rd_data
  );

endinterface

// File: rtl/regmst_timeout_cnt.sv
// Wait-for-ack watchdog: cleared when a command is accepted, counts while running,
// expired is a registered flag high from the TIMEOUT_CYCLES-th running cycle on.
module regmst_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // expired is looked ahead one count so the FSM reacts on the last waiting cycle
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q   <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      cnt_q   <= '0;
      expired <= (TIMEOUT_CYCLES <= 1);
    end else if (run && !expired) begin
      cnt_q   <= cnt_inc;
      expired <= (cnt_inc == CNT_W'(TIMEOUT_CYCLES - 1));
    end
  end

endmodule

// File: rtl/regmst_initiator.sv
// Initiator end of the req_vld/ack_vld register protocol: one transaction at a time,
// IDLE -> WAIT_ACK -> RSP -> GAP. Define REGMST_TIMEOUT_EN to abort unanswered requests.
module regmst_initiator
  import regmst_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = ADDR_W,
  parameter int unsigned DATA_WIDTH     = DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                clk,
  input logic                rstn,
  regmst_initiator_if.master bus
);

  if (ADDR_WIDTH != ADDR_W || DATA_WIDTH != DATA_W || TIMEOUT_CYCLES == 0) begin : g_cfg_err
    $error("regmst_initiator: widths must match regmst_pkg and TIMEOUT_CYCLES must be nonzero");
  end

  regmst_state_e     state_q, state_d;
  regmst_cmd_t       cmd_q, cmd_d;
  logic              cmd_rdy_q, cmd_rdy_d;
  logic              req_vld_q, req_vld_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic              gsr_q, gsr_d;
  logic              rsp_vld_q, rsp_vld_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

`ifdef REGMST_TIMEOUT_EN
  logic tmo_expired;

  regmst_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk     (clk),
    .rstn    (rstn),
    .clear   ((state_q == IDLE) && bus.cmd_vld),
    .run     (state_q == WAIT_ACK),
    .expired (tmo_expired)
  );
`endif

  // next state and next registered outputs
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cmd_rdy_d   = cmd_rdy_q;
    req_vld_d   = req_vld_q;
    wr_en_d     = wr_en_q;
    rd_en_d     = rd_en_q;
    gsr_d       = gsr_q;
    rsp_vld_d   = rsp_vld_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_vld) begin
          cmd_d.wr       = bus.cmd_wr;
          cmd_d.sync_rst = bus.cmd_sync_rst;
          cmd_d.addr     = ADDR_W'(bus.cmd_addr);
          cmd_d.wdata    = DATA_W'(bus.cmd_wdata);
          req_vld_d      = ~bus.cmd_sync_rst;
          wr_en_d        = ~bus.cmd_sync_rst & bus.cmd_wr;
          rd_en_d        = ~bus.cmd_sync_rst & ~bus.cmd_wr;
          gsr_d          = bus.cmd_sync_rst;
          cmd_rdy_d      = 1'b0;
          state_d        = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        if (bus.ack_vld) begin
          // only a real read returns slave data
          rsp_rdata_d = (cmd_q.wr || cmd_q.sync_rst) ? '0 : DATA_W'(bus.rd_data);
          rsp_err_d   = 1'b0;
          rsp_vld_d   = 1'b1;
          req_vld_d   = 1'b0;
          wr_en_d     = 1'b0;
          rd_en_d     = 1'b0;
          gsr_d       = 1'b0;
          state_d     = RSP;
        end
`ifdef REGMST_TIMEOUT_EN
        else if (tmo_expired) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_vld_d   = 1'b1;
          req_vld_d   = 1'b0;
          wr_en_d     = 1'b0;
          rd_en_d     = 1'b0;
          gsr_d       = 1'b0;
          state_d     = RSP;
        end
`endif
      end

      RSP: begin
        if (bus.rsp_rdy) begin
          rsp_vld_d   = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          state_d     = GAP;
        end
      end

      GAP: begin
        // hold req_vld low until the slave releases ack so every request has a fresh rising edge
        if (!bus.ack_vld) begin
          cmd_rdy_d = 1'b1;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        cmd_rdy_d = 1'b1;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b1;
      req_vld_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      gsr_q       <= 1'b0;
      rsp_vld_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      req_vld_q   <= req_vld_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      gsr_q       <= gsr_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.cmd_rdy               = cmd_rdy_q;
  assign bus.req_vld               = req_vld_q;
  assign bus.wr_en                 = wr_en_q;
  assign bus.rd_en                 = rd_en_q;
  assign bus.addr                  = ADDR_WIDTH'(cmd_q.addr);
  assign bus.wr_data               = DATA_WIDTH'(cmd_q.wdata);
  assign bus.global_sync_reset_out = gsr_q;
  assign bus.rsp_vld               = rsp_vld_q;
  assign bus.rsp_rdata             = DATA_WIDTH'(rsp_rdata_q);
  assign bus.rsp_err               = rsp_err_q;

endmodule
